// File: rtl/common_pkg.sv
// Shared definitions for the bus fabric.
//   WB_ADDR_WIDTH        : default Wishbone / command address width
//   DATA_WIDTH           : default data bus width
//   wb_initiator_state_t : wb_initiator FSM encoding, exported so benches can probe it
package common_pkg;

  localparam int WB_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    WAIT_ACK = 2'd2
  } wb_initiator_state_t;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone B4 pipelined initiator. Turns a valid/ready command into one
// single-beat Wishbone transaction at a time. A watchdog aborts transactions
// that are never acked and reports them through rsp_err_o.
//
// Ports:
//   wb_clock_i, wb_reset_i        : clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o     : command handshake (accepted on valid & ready)
//   cmd_addr_i, cmd_data_i, cmd_we_i : command address, write data, write enable
//   rsp_valid_o                   : one-cycle completion pulse
//   rsp_data_o                    : read data, held until the next read completes
//   rsp_err_o                     : qualifies rsp_valid_o; 1 = watchdog abort
//   wb_addr_o, wb_data_o, wb_we_o : Wishbone address / write data / write enable
//   wb_cycle_o, wb_strobe_o       : Wishbone CYC / STB
//   wb_data_i, wb_ack_i, wb_stall_i : Wishbone read data / ACK / STALL
module wb_initiator
  import common_pkg::*;
#(
  parameter int ADDR_WIDTH     = common_pkg::WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = common_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  input  logic                  cmd_we_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_we_o,
  output logic                  wb_cycle_o,
  output logic                  wb_strobe_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i
);

  // A zero timeout would give a zero-width counter; keep at least one bit.
  localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 1) ? 1 : WD_RAW;
  localparam bit WD_EN  = (TIMEOUT_CYCLES != 0);
  // Abort on the edge where the counter would step onto TIMEOUT_CYCLES.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  wb_initiator_state_t state_reg, state_next;
  logic [WD_W-1:0]       wd_reg, wd_next;
  logic                  ready_reg, ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  we_reg, we_next;
  logic                  cyc_reg, cyc_next;
  logic                  stb_reg, stb_next;

  logic ack_taken;
  logic wd_expired;

  always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      state_reg     <= IDLE;
      wd_reg        <= '0;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wd_reg        <= wd_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      we_reg        <= we_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wd_next        = wd_reg;
    ready_next     = ready_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = 1'b0;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    we_next        = we_reg;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    ack_taken      = 1'b0;
    wd_expired     = WD_EN && (wd_reg == WD_LAST);

    unique case (state_reg)
      IDLE: begin
        wd_next = '0;
        // Any ack seen here belongs to no transaction and is dropped.
        if (cmd_valid_i && ready_reg) begin
          addr_next  = cmd_addr_i;
          wdata_next = cmd_data_i;
          we_next    = cmd_we_i;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          ready_next = 1'b0;
          state_next = REQUEST;
        end
      end

      REQUEST: begin
        wd_next = wd_reg + 1'b1;
        if (!wb_stall_i) begin
          // Strobe accepted this edge; a same-edge ack finishes immediately.
          stb_next   = 1'b0;
          ack_taken  = wb_ack_i;
          state_next = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        wd_next   = wd_reg + 1'b1;
        ack_taken = wb_ack_i;
      end

      default: begin
        state_next = IDLE;
        cyc_next   = 1'b0;
        stb_next   = 1'b0;
        ready_next = 1'b1;
      end
    endcase

    // Completion and abort override the REQUEST/WAIT_ACK moves above;
    // ack has priority over a timeout on the same edge.
    if (state_reg != IDLE) begin
      if (ack_taken) begin
        if (!we_reg) begin
          rsp_data_next = wb_data_i;
        end
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        cyc_next       = 1'b0;
        stb_next       = 1'b0;
        ready_next     = 1'b1;
        state_next     = IDLE;
      end else if (wd_expired) begin
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b1;
        cyc_next       = 1'b0;
        stb_next       = 1'b0;
        ready_next     = 1'b1;
        state_next     = IDLE;
      end
    end
  end

  assign cmd_ready_o = ready_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_data_o  = rsp_data_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign wb_addr_o   = addr_reg;
  assign wb_data_o   = wdata_reg;
  assign wb_we_o     = we_reg;
  assign wb_cycle_o  = cyc_reg;
  assign wb_strobe_o = stb_reg;

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Synthesizable Wishbone B4 pipelined initiator.
- Converts a simple valid/ready command port (from the SPI/MCU bridge side) into single Wishbone transactions towards responders such as bram and the register files.
- One transaction outstanding at a time; a watchdog aborts transactions that never ack.
- Responds with read data, or an error flag on timeout.

Parameters:
- ADDR_WIDTH, default common_pkg::WB_ADDR_WIDTH, width of command and Wishbone address.
- DATA_WIDTH, default common_pkg::DATA_WIDTH, width of the data bus.
- TIMEOUT_CYCLES, default 255, clocks from strobe assertion to forced abort; 0 disables the watchdog.

Ports:
- wb_clock_i  in  1  system clock; all logic on its rising edge.
- wb_reset_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  initiator idle, command accepted when valid&ready.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_data_i  in  DATA_WIDTH  write data.
- cmd_we_i  in  1  1 = write, 0 = read.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  DATA_WIDTH  read data; held until next completion.
- rsp_err_o  out  1  valid with rsp_valid_o; 1 = timeout abort.
- wb_addr_o  out  ADDR_WIDTH  Wishbone address.
- wb_data_o  out  DATA_WIDTH  Wishbone write data.
- wb_data_i  in  DATA_WIDTH  Wishbone read data.
- wb_we_o  out  1  Wishbone write enable.
- wb_cycle_o  out  1  Wishbone CYC.
- wb_strobe_o  out  1  Wishbone STB.
- wb_ack_i  in  1  Wishbone ACK.
- wb_stall_i  in  1  Wishbone STALL.

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready_o = 1 once reset deasserts.
  - All other outputs = 0, including rsp_data_o.
  - State = IDLE, watchdog = 0.
- Reset asserted mid-transaction drops cycle/strobe immediately (asynchronously). No rsp_valid_o is generated for the killed transaction.
- States: IDLE, REQUEST, WAIT_ACK.
- IDLE:
  - cmd_ready_o = 1.
  - On valid&ready at edge E: latch addr/data/we onto the wb_*_o outputs; assert cycle and strobe after E; clear cmd_ready_o; go to REQUEST.
- REQUEST:
  - Strobe stays high while wb_stall_i = 1.
  - At the first edge sampling stall = 0, strobe drops.
  - If ack is also sampled at that edge, complete directly. Otherwise go to WAIT_ACK.
- WAIT_ACK:
  - At the edge sampling ack = 1:
    - Capture wb_data_i into rsp_data_o (reads only; writes leave rsp_data_o unchanged).
    - Drop cycle.
    - Pulse rsp_valid_o with rsp_err_o = 0.
    - Return to IDLE with cmd_ready_o = 1.
- Zero-stall responder (bram) latency:
  - Command accepted at edge 0.
  - Responder samples strobe at edge 1 and acks.
  - Initiator samples ack at edge 2; rsp_valid_o and cmd_ready_o are high after edge 2.
  - Throughput is one transaction per 3 clocks. Back-to-back acceptance in the rsp_valid_o cycle is permitted.
- Watchdog:
  - Counter clears on command acceptance and increments each clock in REQUEST/WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES: drop cycle and strobe, pulse rsp_valid_o with rsp_err_o = 1, leave rsp_data_o unchanged, return to IDLE.
  - If ack arrives on the same edge as the timeout, ack wins (err = 0).
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Ack sampled while cycle = 0 is ignored; no spurious rsp_valid_o.
- wb_addr_o, wb_data_o and wb_we_o are stable for the whole cycle.
- cmd_* inputs are ignored while cmd_ready_o = 0.

Decomposition:
- common_pkg supplies WB_ADDR_WIDTH and DATA_WIDTH.
- Add wb_initiator_state_t (IDLE/REQUEST/WAIT_ACK) to common_pkg so benches can probe state.
- No sub-module: the watchdog is an inline counter.

Test Plan:
- Write then read against bram with zero stall:
  - Stimulus: cmd write 0x000 <= 0x55, then read 0x000.
  - Response: rsp_data_o = 0x55, err = 0; each rsp_valid_o arrives exactly 2 clocks after acceptance; wb_stall_i never asserted.
- Stalling responder model:
  - Stimulus: stall held for 3 clocks, read 0x123 returns 0xA7.
  - Response: strobe high for 4 clocks; addr stable throughout; rsp_data_o = 0xA7.
- Same-edge ack:
  - Stimulus: responder acks combinationally on the accepted-strobe edge.
  - Response: completes from REQUEST with no WAIT_ACK cycle; one rsp_valid_o pulse.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, responder never acks.
  - Response: cycle drops after 8 clocks; rsp_valid_o = 1 with rsp_err_o = 1; rsp_data_o unchanged; next command accepted normally.
- Reset mid-transaction:
  - Stimulus: assert wb_reset_i while in WAIT_ACK.
  - Response: cycle/strobe are 0 before the next clock edge; no rsp_valid_o; after release, cmd_ready_o = 1 and a read of 0x000 succeeds.
- Spurious ack:
  - Stimulus: pulse wb_ack_i in IDLE.
  - Response: no rsp_valid_o; state remains IDLE.
